chimera_cluster_pwr_seq: RTL and testbench

Parametrised successor to the static per-cluster clock-gate configuration. It sequences clock enable, reset release and output isolation for NumClusters accelerator clusters with programmable settle and hold delays. Cluster transitions are serialised, one at a time, to limit inrush, and a cluster is drained before power-down. It sits between the top-level register file (per-cluster enable and delay fields) and the per-cluster clock gates, reset lines and isolation cells.

---
 rtl/chimera_cluster_pwr_seq.sv | 175 +++++++++++++++++
 tb/tb_chimera_cluster_pwr_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chimera_cluster_pwr_seq.sv
// Power sequencer for accelerator clusters. It moves one cluster at a time through
// clock enable, reset release and isolation on power-up, and the reverse on power-down.
module chimera_cluster_pwr_seq #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned CntWidth    = 8,
  parameter int unsigned IdxWidth    = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] cluster_en_i,
  input  logic [CntWidth-1:0]    clk_settle_i,
  input  logic [CntWidth-1:0]    rst_hold_i,
  input  logic [CntWidth-1:0]    drain_timeout_i,
  input  logic [NumClusters-1:0] cluster_idle_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] rst_no,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] active_o,
  output logic [NumClusters-1:0] timeout_o,
  output logic                   busy_o,
  output logic [IdxWidth-1:0]    cur_idx_o,
  output logic [2:0]             dbg_state_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StUpClk = 3'd1;
  localparam logic [2:0] StUpRst = 3'd2;
  localparam logic [2:0] StDnIso = 3'd3;
  localparam logic [2:0] StDnRst = 3'd4;

  localparam logic [IdxWidth:0]   NumW   = (IdxWidth+1)'(NumClusters);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [2:0]             state_q, state_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] rst_n_q, rst_n_d;
  logic [NumClusters-1:0] iso_q, iso_d;
  logic [NumClusters-1:0] active_q, active_d;
  logic [NumClusters-1:0] timeout_q, timeout_d;

  logic [NumClusters-1:0] pending;
  logic                   found;
  logic [IdxWidth-1:0]    sel_idx;
  logic [IdxWidth:0]      cand;
  logic [IdxWidth:0]      ptr_inc;
  logic [IdxWidth-1:0]    ptr_nxt;
  logic                   cnt_zero;

  assign pending  = cluster_en_i ^ active_q;
  assign cnt_zero = (cnt_q == '0);

  // Round-robin scan: first pending cluster at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(NumClusters); k++) begin
      cand = {1'b0, ptr_q} + (IdxWidth+1)'(k);
      if (cand >= NumW) cand = cand - NumW;
      if (!found && pending[cand[IdxWidth-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[IdxWidth-1:0];
      end
    end
  end

  assign ptr_inc = {1'b0, sel_idx} + (IdxWidth+1)'(1);
  assign ptr_nxt = (ptr_inc >= NumW) ? '0 : ptr_inc[IdxWidth-1:0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    iso_d     = iso_q;
    active_d  = active_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          idx_d = sel_idx;
          ptr_d = ptr_nxt;
          if (active_q[sel_idx]) begin
            iso_d[sel_idx]     = 1'b1;
            active_d[sel_idx]  = 1'b0;
            timeout_d[sel_idx] = 1'b0;
            cnt_d              = drain_timeout_i;
            state_d            = StDnIso;
          end else begin
            clk_en_d[sel_idx] = 1'b1;
            cnt_d             = clk_settle_i;
            state_d           = StUpClk;
          end
        end
      end
      StUpClk: begin
        if (cnt_zero) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = rst_hold_i;
          state_d        = StUpRst;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StUpRst: begin
        if (cnt_zero) begin
          active_d[idx_q] = 1'b1;
          iso_d[idx_q]    = 1'b0;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDnIso: begin
        // Idle seen on the last counter cycle still counts as a clean drain.
        if (cluster_idle_i[idx_q] || cnt_zero) begin
          if (!cluster_idle_i[idx_q]) timeout_d[idx_q] = 1'b1;
          rst_n_d[idx_q] = 1'b0;
          cnt_d          = rst_hold_i;
          state_d        = StDnRst;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDnRst: begin
        if (cnt_zero) begin
          clk_en_d[idx_q] = 1'b0;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      iso_q     <= '1;
      active_q  <= '0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      iso_q     <= iso_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  assign clk_en_o    = clk_en_q;
  assign rst_no      = rst_n_q;
  assign isolate_o   = iso_q;
  assign active_o    = active_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = (state_q != StIdle);
  assign cur_idx_o   = idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Directed bench for the cluster power sequencer: latency, serialisation,
// drain/timeout behaviour, round-robin fairness and asynchronous reset.
module tb_chimera_cluster_pwr_seq;

  localparam int N  = 5;
  localparam int CW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en, idle;
  logic [CW-1:0] settle, hold, dto;
  logic [N-1:0]  clk_en, rst_no, iso, active, timeout;
  logic          busy;
  logic [IW-1:0] cur_idx;
  logic [2:0]    dbg_state;

  logic [N-1:0]  e_clk, e_rst, e_act;
  int            n_pass = 0;
  int            n_checks = 0;

  chimera_cluster_pwr_seq #(.NumClusters(N), .CntWidth(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cluster_en_i   (en),
    .clk_settle_i   (settle),
    .rst_hold_i     (hold),
    .drain_timeout_i(dto),
    .cluster_idle_i (idle),
    .clk_en_o       (clk_en),
    .rst_no         (rst_no),
    .isolate_o      (iso),
    .active_o       (active),
    .timeout_o      (timeout),
    .busy_o         (busy),
    .cur_idx_o      (cur_idx),
    .dbg_state_o    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_en"},  32'(clk_en),  32'h0);
    check({tag, "_rst_no"},  32'(rst_no),  32'h0);
    check({tag, "_iso"},     32'(iso),     32'h1f);
    check({tag, "_active"},  32'(active),  32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
    check({tag, "_busy"},    32'(busy),    32'h0);
    check({tag, "_cur_idx"}, 32'(cur_idx), 32'h0);
    check({tag, "_state"},   32'(dbg_state), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; en = '0; idle = '0; settle = '0; hold = '0; dto = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");

    // Single power-up of cluster 0, S=3 R=2: clk_en @1, rst_no @5, active @8.
    rst_n = 1'b1; en = 5'b00001; settle = 8'd3; hold = 8'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t1_clk_en", 32'(clk_en), (c >= 1) ? 32'h1 : 32'h0);
      check("t1_rst_no", 32'(rst_no), (c >= 5) ? 32'h1 : 32'h0);
      check("t1_active", 32'(active), (c >= 8) ? 32'h1 : 32'h0);
      check("t1_iso",    32'(iso),    (c >= 8) ? 32'h1e : 32'h1f);
      check("t1_busy",   32'(busy),   (c < 8) ? 32'h1 : 32'h0);
    end

    // All clusters at once, S=R=0: cluster k on from cycle 3k+1, active at 3k+3.
    rst_n = 1'b0;
    #1 check_reset_vals("rst1");
    @(negedge clk);
    rst_n = 1'b1; en = 5'b11111; settle = 8'd0; hold = 8'd0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        e_clk[k] = (c >= 3*k + 1);
        e_rst[k] = (c >= 3*k + 2);
        e_act[k] = (c >= 3*k + 3);
      end
      check("t2_clk_en", 32'(clk_en), 32'(e_clk));
      check("t2_rst_no", 32'(rst_no), 32'(e_rst));
      check("t2_active", 32'(active), 32'(e_act));
      check("t2_busy",   32'(busy),   (c % 3 != 0) ? 32'h1 : 32'h0);
      if (c % 3 != 0) check("t2_cur_idx", 32'(cur_idx), 32'(c / 3));
    end

    // Power-down cluster 2 with no idle, D=4 R=2: rst_no falls @6, clk off @9.
    en = 5'b11011; dto = 8'd4; hold = 8'd2; idle = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t3_iso",     32'(iso),     32'h04);
      check("t3_active",  32'(active),  32'h1b);
      check("t3_rst_no",  32'(rst_no),  (c < 6) ? 32'h1f : 32'h1b);
      check("t3_timeout", 32'(timeout), (c >= 6) ? 32'h04 : 32'h0);
      check("t3_clk_en",  32'(clk_en),  (c < 9) ? 32'h1f : 32'h1b);
      check("t3_busy",    32'(busy),    (c < 9) ? 32'h1 : 32'h0);
      if (c < 9) check("t3_cur_idx", 32'(cur_idx), 32'h2);
    end

    // Bring cluster 2 back; timeout stays sticky until the next power-down.
    en = 5'b11111; settle = 8'd0; hold = 8'd0;
    repeat (3) @(negedge clk);
    check("t4a_up_active",  32'(active),  32'h1f);
    check("t4a_up_timeout", 32'(timeout), 32'h04);

    // Power-down with idle rising in the second DN_ISO cycle, R=1.
    en = 5'b11011; dto = 8'd4; hold = 8'd1; idle = '0;
    @(negedge clk);
    check("t4a_timeout_clr", 32'(timeout), 32'h0);
    check("t4a_iso",         32'(iso),     32'h04);
    @(negedge clk);
    check("t4a_rst_hold", 32'(rst_no), 32'h1f);
    idle = 5'b00100;
    @(negedge clk);
    check("t4a_rst_fall", 32'(rst_no),  32'h1b);
    check("t4a_no_to",    32'(timeout), 32'h0);
    @(negedge clk);
    check("t4a_clk_hold", 32'(clk_en), 32'h1f);
    check("t4a_busy",     32'(busy),   32'h1);
    @(negedge clk);
    check("t4a_clk_off",  32'(clk_en), 32'h1b);
    check("t4a_idle",     32'(busy),   32'h0);

    // Idle arriving on the very cycle the counter hits zero: no timeout.
    idle = '0; en = 5'b11111; settle = 8'd0; hold = 8'd0;
    repeat (3) @(negedge clk);
    check("t4b_up_active", 32'(active), 32'h1f);
    en = 5'b11011; dto = 8'd2; hold = 8'd0;
    repeat (3) @(negedge clk);
    check("t4b_rst_hold", 32'(rst_no), 32'h1f);
    idle = 5'b00100;
    @(negedge clk);
    check("t4b_rst_fall", 32'(rst_no),  32'h1b);
    check("t4b_no_to",    32'(timeout), 32'h0);
    @(negedge clk);
    check("t4b_clk_off",  32'(clk_en),  32'h1b);
    check("t4b_idle",     32'(busy),    32'h0);

    // Fairness: cluster 3 waits while cluster 0 flips; pointer sits at 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 5'b00001; settle = 8'd0; hold = 8'd0; idle = 5'b11111;
    @(negedge clk);
    check("t5_first_idx", 32'(cur_idx), 32'h0);
    en = 5'b01001;
    repeat (2) @(negedge clk);
    check("t5_c0_active", 32'(active), 32'h01);
    en = 5'b01000;
    @(negedge clk);
    check("t5_rr_idx",  32'(cur_idx), 32'h3);
    check("t5_rr_clk",  32'(clk_en),  32'h09);
    repeat (2) @(negedge clk);
    check("t5_c3_active", 32'(active), 32'h09);
    @(negedge clk);
    check("t5_c0_down_idx", 32'(cur_idx), 32'h0);
    check("t5_c0_down_iso", 32'(iso),     32'h17);
    repeat (2) @(negedge clk);
    check("t5_final_clk",    32'(clk_en), 32'h08);
    check("t5_final_active", 32'(active), 32'h08);
    check("t5_final_busy",   32'(busy),   32'h0);

    // Asynchronous reset in the middle of UP_RST, then restart from pointer 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 5'b00001; settle = 8'd3; hold = 8'd4; idle = '0;
    repeat (6) @(negedge clk);
    check("t6_in_uprst", 32'(rst_no), 32'h01);
    check("t6_busy",     32'(busy),   32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6_async");
    en = 5'b00011; settle = 8'd0; hold = 8'd0;
    @(negedge clk);
    check_reset_vals("t6_held");
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_idx", 32'(cur_idx), 32'h0);
    check("t6_restart_clk", 32'(clk_en),  32'h01);
    repeat (2) @(negedge clk);
    check("t6_c0_active", 32'(active), 32'h01);
    @(negedge clk);
    check("t6_next_idx", 32'(cur_idx), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
